// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   - Default geometry: digit count, clocks per digit slot, blanking length.
//   - Scan state encoding (BLANK=0, SHOW=1).
package seven_seg_scan_ctrl_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_REFRESH_DIV  = 25000;
  localparam int DEF_BLANK_CYCLES = 16;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot counter plus digit index for the scan controller.
// Ports:
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   o_Digit_Idx       digit currently being scanned
//   o_Slot_Start      counter == 0 (first cycle of a slot)
//   o_Blank_Phase     counter < BLANK_CYCLES
//   o_Blank_Last      counter == BLANK_CYCLES-1 (next cycle starts SHOW)
//   o_Wrap            counter == REFRESH_DIV-1 (last cycle of a slot)
//   o_Frame_Last      wrap on the last digit (last cycle of a frame)
module scan_slot_timer
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  output logic [$clog2(NUM_DIGITS)-1:0] o_Digit_Idx,
  output logic                          o_Slot_Start,
  output logic                          o_Blank_Phase,
  output logic                          o_Blank_Last,
  output logic                          o_Wrap,
  output logic                          o_Frame_Last
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LEN  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign o_Digit_Idx   = idx_q;
  assign o_Slot_Start  = (cnt_q == '0);
  assign o_Blank_Phase = (cnt_q < BLANK_LEN);
  assign o_Blank_Last  = (cnt_q == BLANK_END);
  assign o_Wrap        = (cnt_q == CNT_LAST);
  assign o_Frame_Last  = o_Wrap && (idx_q == IDX_LAST);

  // Explicit wrap compare: REFRESH_DIV / NUM_DIGITS need not be powers of 2.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (o_Wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. Feeds one nibble per digit
// slot to an external registered hex decoder and drives a one-hot digit
// select with a leading blank gap per slot. New values are staged in a
// pending register and commit only on the last cycle of a frame.
// Ports:
//   i_Clk, i_Rst   clock, synchronous active-high reset
//   i_Load         load strobe, honoured when o_Ready=1
//   i_Value        display value, nibble k = digit k (digit 0 at LSB)
//   i_Lz_Blank     suppress leading zero digits (sampled per slot)
//   o_Ready        no load pending
//   o_Binary_Num   nibble to decoder input
//   o_Digit_Sel    one-hot digit enable, all zero while blanking
//   o_Frame_Done   pulse on the last cycle of each frame
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Lz_Blank,
  output logic                    o_Ready,
  output logic [3:0]              o_Binary_Num,
  output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
  output logic                    o_Frame_Done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("NUM_DIGITS must be at least 2");
  end
  if (BLANK_CYCLES < 2) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 2");
  end
  if (REFRESH_DIV <= BLANK_CYCLES) begin : g_bad_div
    $error("REFRESH_DIV must exceed BLANK_CYCLES");
  end

  logic [IDX_W-1:0] idx;
  logic             slot_start, blank_phase, blank_last, wrap, frame_last;

  scan_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .o_Digit_Idx  (idx),
    .o_Slot_Start (slot_start),
    .o_Blank_Phase(blank_phase),
    .o_Blank_Last (blank_last),
    .o_Wrap       (wrap),
    .o_Frame_Last (frame_last)
  );

  // ---------------------------------------------------------------------
  // Value staging: pending -> active at frame boundary only.
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] active_q, active_d;
  logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d;
  logic                       pend_vld_q, pend_vld_d;

  // Accept needs !pend_vld_q and commit needs pend_vld_q, so they never
  // fire together; a load on the frame-last cycle only reaches pending.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_last && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (i_Load && !pend_vld_q) begin
      pend_d     = i_Value;
      pend_vld_d = 1'b1;
    end
  end

  assign o_Ready = ~pend_vld_q;

  // Digit k is a leading zero when it and every digit above it are 0.
  // Digit 0 is never masked so a zero value still shows "0".
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (active_q[k] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  // ---------------------------------------------------------------------
  // Per-slot datapath: nibble and suppression latch on the first blank
  // cycle so the decoder has settled before the select rises.
  // ---------------------------------------------------------------------
  logic [3:0] bin_q, bin_d;
  logic       supp_q, supp_d;

  always_comb begin
    bin_d  = bin_q;
    supp_d = supp_q;
    if (slot_start) begin
      bin_d  = active_q[idx];
      supp_d = i_Lz_Blank && lz_mask[idx];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bin_q      <= 4'h0;
      supp_q     <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bin_q      <= bin_d;
      supp_q     <= supp_d;
    end
  end

  assign o_Binary_Num = bin_q;
  assign o_Frame_Done = frame_last;

  // ---------------------------------------------------------------------
  // Scan FSM: BLANK / SHOW, tracking the slot counter phase.
  // ---------------------------------------------------------------------
  scan_state_e state_q, state_d;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_BLANK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (blank_phase) state_d = blank_last ? ST_SHOW : ST_BLANK;
    else             state_d = wrap ? ST_BLANK : ST_SHOW;
  end

  logic [NUM_DIGITS-1:0] sel_onehot;
  assign sel_onehot = NUM_DIGITS'(1) << idx;

  always_comb begin
    o_Digit_Sel = '0;
    if (state_q == ST_SHOW && !supp_q) o_Digit_Sel = sel_onehot;
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b1;
  logic          i_Load = 1'b0;
  logic [4*ND-1:0] i_Value = '0;
  logic          i_Lz_Blank = 1'b0;
  logic          o_Ready;
  logic [3:0]    o_Binary_Num;
  logic [ND-1:0] o_Digit_Sel;
  logic          o_Frame_Done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Load      (i_Load),
    .i_Value     (i_Value),
    .i_Lz_Blank  (i_Lz_Blank),
    .o_Ready     (o_Ready),
    .o_Binary_Num(o_Binary_Num),
    .o_Digit_Sel (o_Digit_Sel),
    .o_Frame_Done(o_Frame_Done)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle 0 is the period right after the last edge that sampled reset.
  task automatic do_reset();
    @(posedge i_Clk); #1;
    i_Rst = 1'b1; i_Load = 1'b0;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    cyc = 0;
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge i_Clk); #1;
      cyc++;
    end
  endtask

  task automatic load(input logic [4*ND-1:0] v);
    i_Load = 1'b1; i_Value = v;
    go(cyc + 1);
    i_Load = 1'b0;
  endtask

  initial begin
    // 1: reset state and scan timing
    do_reset();
    chk("rst_sel",   o_Digit_Sel, 4'b0000);
    chk("rst_ready", o_Ready, 1);
    chk("rst_bin",   o_Binary_Num, 0);
    chk("rst_fd",    o_Frame_Done, 0);
    go(1);  chk("blank1_sel", o_Digit_Sel, 4'b0000);
    go(2);  chk("s0_sel_c2",  o_Digit_Sel, 4'b0001);
    go(7);  chk("s0_sel_c7",  o_Digit_Sel, 4'b0001);
    go(8);  chk("s1_blank",   o_Digit_Sel, 4'b0000);
    go(10); chk("s1_sel_c10", o_Digit_Sel, 4'b0010);
    go(15); chk("s1_sel_c15", o_Digit_Sel, 4'b0010);
    go(30); chk("fd_c30", o_Frame_Done, 0);
    go(31); chk("fd_c31", o_Frame_Done, 1);
    go(32); chk("fd_c32", o_Frame_Done, 0);

    // 2+3: load, ignored load while busy, commit at frame boundary
    do_reset();
    go(5);  load(16'h1234);
    chk("ld_ready_c6", o_Ready, 0);
    go(10); chk("f1_bin_d1", o_Binary_Num, 0);
    load(16'hFFFF);
    chk("busy_ready", o_Ready, 0);
    go(26); chk("f1_bin_d3", o_Binary_Num, 0);
    go(31); chk("ready_c31", o_Ready, 0);
    go(32); chk("ready_c32", o_Ready, 1);
    go(34); chk("f2_sel0", o_Digit_Sel, 4'b0001); chk("f2_bin0", o_Binary_Num, 4'h4);
    go(42); chk("f2_sel1", o_Digit_Sel, 4'b0010); chk("f2_bin1", o_Binary_Num, 4'h3);
    go(50); chk("f2_sel2", o_Digit_Sel, 4'b0100); chk("f2_bin2", o_Binary_Num, 4'h2);
    go(58); chk("f2_sel3", o_Digit_Sel, 4'b1000); chk("f2_bin3", o_Binary_Num, 4'h1);
    go(64); chk("no_pend_ready", o_Ready, 1);
    go(66); chk("f3_bin0", o_Binary_Num, 4'h4);

    // 4: load on the frame-last cycle goes to pending only
    do_reset();
    go(31); chk("bnd_ready_c31", o_Ready, 1);
    load(16'hABCD);
    chk("bnd_ready_c32", o_Ready, 0);
    go(34); chk("bnd_f2_bin0", o_Binary_Num, 0);
    go(58); chk("bnd_f2_bin3", o_Binary_Num, 0);
    go(63); chk("bnd_ready_c63", o_Ready, 0);
    go(64); chk("bnd_ready_c64", o_Ready, 1);
    go(66); chk("bnd_bin0", o_Binary_Num, 4'hD);
    go(74); chk("bnd_bin1", o_Binary_Num, 4'hC);
    go(82); chk("bnd_bin2", o_Binary_Num, 4'hB);
    go(90); chk("bnd_bin3", o_Binary_Num, 4'hA);

    // 5: leading-zero blanking
    do_reset();
    i_Lz_Blank = 1'b1;
    load(16'h0050);
    go(32); load(16'h0000);
    go(34); chk("lz50_sel0", o_Digit_Sel, 4'b0001); chk("lz50_bin0", o_Binary_Num, 4'h0);
    go(42); chk("lz50_sel1", o_Digit_Sel, 4'b0010); chk("lz50_bin1", o_Binary_Num, 4'h5);
    go(50); chk("lz50_sel2", o_Digit_Sel, 4'b0000);
    go(58); chk("lz50_sel3", o_Digit_Sel, 4'b0000);
    go(66); chk("lz00_sel0", o_Digit_Sel, 4'b0001);
    go(74); chk("lz00_sel1", o_Digit_Sel, 4'b0000);
    go(82); chk("lz00_sel2", o_Digit_Sel, 4'b0000);
    go(90); chk("lz00_sel3", o_Digit_Sel, 4'b0000);
    i_Lz_Blank = 1'b0;
    go(96);
    go(98); chk("nolz_sel0", o_Digit_Sel, 4'b0001);
    go(106); chk("nolz_sel1", o_Digit_Sel, 4'b0010);

    // 6: reset mid-frame with a pending load
    do_reset();
    load(16'h1234);
    go(18); chk("pre_rst_sel", o_Digit_Sel, 4'b0100);
    chk("pre_rst_ready", o_Ready, 0);
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    chk("mid_rst_sel",   o_Digit_Sel, 4'b0000);
    chk("mid_rst_ready", o_Ready, 1);
    chk("mid_rst_bin",   o_Binary_Num, 0);
    chk("mid_rst_fd",    o_Frame_Done, 0);
    i_Rst = 1'b0;
    cyc = 0;
    go(2);  chk("restart_sel", o_Digit_Sel, 4'b0001);
    go(31); chk("restart_fd", o_Frame_Done, 1);
    go(34); chk("dropped_bin0", o_Binary_Num, 0);
    go(58); chk("dropped_bin3", o_Binary_Num, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexes one registered hex-to-segment decoder across NUM_DIGITS common-cathode/anode digits. Holds a display value and feeds one 4-bit nibble per slot to the decoder. Drives a one-hot digit select with a blanking gap per slot to prevent ghosting. New values load through a ready/load handshake and commit only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned; at least 2.
REFRESH_DIV, 25000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, leading cycles of each slot with all selects low; at least 2, to cover the decoder's 1-cycle latency.

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset, synchronous, active-high
i_Load  in  1  load strobe; honoured only when o_Ready=1
i_Value  in  4*NUM_DIGITS  display value; nibble k is digit k, and digit 0 is the LSB
i_Lz_Blank  in  1  suppress leading zero digits; sampled each slot
o_Ready  out  1  high when no load is pending
o_Binary_Num  out  4  nibble to the decoder input
o_Digit_Sel  out  NUM_DIGITS  one-hot active-high digit enable; all zero during blanking
o_Frame_Done  out  1  1-cycle pulse on the last cycle of each frame

Behaviour:
- Reset values: o_Digit_Sel=0, o_Binary_Num=0, o_Ready=1, o_Frame_Done=0; active value=0, pending invalid, digit index=0, slot counter=0, state=BLANK. Reset mid-frame discards any pending load. Outputs take reset values at the edge on which i_Rst is sampled high.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0.
- State BLANK (counter 0..BLANK_CYCLES-1):
  - o_Digit_Sel=0.
  - On counter=0, o_Binary_Num is registered as the active nibble of the current digit index.
- State SHOW (counter BLANK_CYCLES..REFRESH_DIV-1):
  - o_Digit_Sel = one-hot(digit index), unless that digit is suppressed, in which case it stays 0.
  - Transitions to BLANK when the counter wraps.
- Digit index: increments on counter wrap; wraps from NUM_DIGITS-1 to 0. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- Suppression (i_Lz_Blank=1): digit k is suppressed if every nibble from k up to NUM_DIGITS-1 is 0 and k is not 0. Digit 0 is always shown, so a value of 0 displays "0".
- Handshake:
  - i_Load=1 with o_Ready=1 captures i_Value into the pending register; o_Ready goes 0 the next cycle.
  - i_Load while o_Ready=0 is ignored, and pending is unchanged.
- Commit: on the last frame cycle (digit NUM_DIGITS-1, counter REFRESH_DIV-1), o_Frame_Done=1. If pending is valid, active<=pending and o_Ready returns to 1 the next cycle.
- Simultaneous load and frame boundary: a load accepted on the last frame cycle goes to pending only. It commits at the next frame boundary; there is no bypass.
- Nibble changes are visible only in BLANK, so the decoder output always settles before the select rises.

Decomposition:
- Shared include/package seven_seg_defs: default REFRESH_DIV, BLANK_CYCLES and NUM_DIGITS constants, plus the state encodings BLANK=0 and SHOW=1.
- One natural sub-module, scan_slot_timer: the slot counter plus digit index. It outputs the counter-wrap, blank-phase and frame-last flags.
- The decoder is instantiated at top level alongside this block, not inside it.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset check: after reset, o_Digit_Sel=0000, o_Ready=1, o_Binary_Num=0. Cycles 2-7 give o_Digit_Sel=0001. Cycles 10-15 give 0010. o_Frame_Done pulses at cycle 31.
2. Load and commit: load 16'h1234 at cycle 5 -> o_Ready=0 from cycle 6. The first frame shows 0 on all digits. From cycle 32, digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1. o_Ready=1 at cycle 32.
3. Ignored load: while o_Ready=0, load 16'hFFFF -> ignored; the committed value is still the earlier 16'h1234.
4. Boundary load: load 16'hABCD exactly at cycle 31 -> not shown in frame 2; shown from cycle 64.
5. Leading-zero blanking: i_Lz_Blank=1 with value 16'h0050 -> selects assert only in slots 0 and 1 (nibbles 0 and 5); slots 2 and 3 keep o_Digit_Sel=0. Value 16'h0000 -> only digit 0 is shown.
6. Reset mid-operation: i_Rst pulsed during slot 2 with a load pending -> all reset values next cycle, pending dropped, and the scan restarts at digit 0.
